// File: rtl/decoder_8b10b_pkg.sv
// Shared 8b/10b definitions for the encoder and decoder: K constants, RD encoding,
// and the sub-block decode functions.
package decoder_8b10b_pkg;

  localparam logic RD_MINUS = 1'b0;
  localparam logic RD_PLUS  = 1'b1;

  typedef enum logic [1:0] {
    CLS_0 = 2'd0,
    CLS_P = 2'd1,
    CLS_N = 2'd2
  } cls_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] edcba;
    cls_e       cls;
  } dec6_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] hgf;
    cls_e       cls;
  } dec4_t;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  // Order: K28.0..K28.7, K23.7, K27.7, K29.7, K30.7 (abcdeifghj)
  localparam logic [9:0] K_SYM_RDM [0:11] = '{
    10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011,
    10'b0011110010, 10'b0011111010, 10'b0011110110, 10'b0011111000,
    10'b1110101000, 10'b1101101000, 10'b1011101000, 10'b0111101000};
  localparam logic [9:0] K_SYM_RDP [0:11] = '{
    10'b1100001011, 10'b1100000110, 10'b1100001010, 10'b1100001100,
    10'b1100001101, 10'b1100000101, 10'b1100001001, 10'b1100000111,
    10'b0001010111, 10'b0010010111, 10'b0100010111, 10'b1000010111};

  function automatic logic rdApply(input cls_e c, input logic rd);
    return (c == CLS_P) ? RD_PLUS : (c == CLS_N) ? RD_MINUS : rd;
  endfunction

  function automatic dec6_t dec6(input logic [5:0] s);
    dec6_t r;
    int    n;
    n       = $countones(s);
    r.valid = 1'b1;
    r.edcba = 5'd0;
    r.cls   = (n > 3 || s == 6'b000111) ? CLS_P :
              (n < 3 || s == 6'b111000) ? CLS_N : CLS_0;
    case (s)
      6'b100111, 6'b011000:             r.edcba = 5'd0;
      6'b011101, 6'b100010:             r.edcba = 5'd1;
      6'b101101, 6'b010010:             r.edcba = 5'd2;
      6'b110001:                        r.edcba = 5'd3;
      6'b110101, 6'b001010:             r.edcba = 5'd4;
      6'b101001:                        r.edcba = 5'd5;
      6'b011001:                        r.edcba = 5'd6;
      6'b111000, 6'b000111:             r.edcba = 5'd7;
      6'b111001, 6'b000110:             r.edcba = 5'd8;
      6'b100101:                        r.edcba = 5'd9;
      6'b010101:                        r.edcba = 5'd10;
      6'b110100:                        r.edcba = 5'd11;
      6'b001101:                        r.edcba = 5'd12;
      6'b101100:                        r.edcba = 5'd13;
      6'b011100:                        r.edcba = 5'd14;
      6'b010111, 6'b101000:             r.edcba = 5'd15;
      6'b011011, 6'b100100:             r.edcba = 5'd16;
      6'b100011:                        r.edcba = 5'd17;
      6'b010011:                        r.edcba = 5'd18;
      6'b110010:                        r.edcba = 5'd19;
      6'b001011:                        r.edcba = 5'd20;
      6'b101010:                        r.edcba = 5'd21;
      6'b011010:                        r.edcba = 5'd22;
      6'b111010, 6'b000101:             r.edcba = 5'd23;
      6'b110011, 6'b001100:             r.edcba = 5'd24;
      6'b100110:                        r.edcba = 5'd25;
      6'b010110:                        r.edcba = 5'd26;
      6'b110110, 6'b001001:             r.edcba = 5'd27;
      6'b001110, 6'b001111, 6'b110000:  r.edcba = 5'd28;
      6'b101110, 6'b010001:             r.edcba = 5'd29;
      6'b011110, 6'b100001:             r.edcba = 5'd30;
      6'b101011, 6'b010100:             r.edcba = 5'd31;
      default:                          r.valid = 1'b0;
    endcase
    return r;
  endfunction

  function automatic dec4_t dec4(input logic [3:0] s);
    dec4_t r;
    int    n;
    n       = $countones(s);
    r.valid = 1'b1;
    r.hgf   = 3'd0;
    r.cls   = (n > 2 || s == 4'b0011) ? CLS_P :
              (n < 2 || s == 4'b1100) ? CLS_N : CLS_0;
    case (s)
      4'b1011, 4'b0100:                    r.hgf = 3'd0;
      4'b1001:                             r.hgf = 3'd1;
      4'b0101:                             r.hgf = 3'd2;
      4'b1100, 4'b0011:                    r.hgf = 3'd3;
      4'b1101, 4'b0010:                    r.hgf = 3'd4;
      4'b1010:                             r.hgf = 3'd5;
      4'b0110:                             r.hgf = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000:  r.hgf = 3'd7;
      default:                             r.valid = 1'b0;
    endcase
    return r;
  endfunction

  // K28 fghj normalised to its post-001111 form; returns {valid, y}
  function automatic logic [3:0] decK28(input logic [3:0] s);
    case (s)
      4'b0100: return 4'b1_000;
      4'b1001: return 4'b1_001;
      4'b0101: return 4'b1_010;
      4'b0011: return 4'b1_011;
      4'b0010: return 4'b1_100;
      4'b1010: return 4'b1_101;
      4'b0110: return 4'b1_110;
      4'b1000: return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

endpackage

// File: rtl/decoder_8b10b_if.sv
// Symbol-in / byte-out bundle between the lane aligner and the 8b/10b decoder.
interface decoder_8b10b_if;
  logic       i_valid;
  logic [9:0] i_sym;
  logic       i_rd_clr;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_k;
  logic       o_comma;
  logic       o_code_err;
  logic       o_disp_err;
  logic       o_rd;

  modport master (
    output i_valid, i_sym, i_rd_clr,
    input  o_valid, o_data, o_k, o_comma, o_code_err, o_disp_err, o_rd
  );

  modport slave (
    input  i_valid, i_sym, i_rd_clr,
    output o_valid, o_data, o_k, o_comma, o_code_err, o_disp_err, o_rd
  );
endinterface

// File: rtl/decoder_8b10b_dec_6b4b_lut.sv
// Combinational 6b/5b + 4b/3b lookup with validity, disparity class and K flags.
module dec_6b4b_lut
  import decoder_8b10b_pkg::*;
(
  input  logic [5:0] sub6_i,
  input  logic [3:0] sub4_i,
  output logic [4:0] edcba_o,
  output logic [2:0] hgf_o,
  output logic       valid6_o,
  output logic       valid4_o,
  output cls_e       cls6_o,
  output cls_e       cls4_o,
  output logic       k28_o,
  output logic       kx7_o,
  output logic       comma_o,
  output logic       a7Minus_o,
  output logic       a7Plus_o,
  output logic       isA7_o,
  output logic       isP7_o
);

  dec6_t      d6;
  dec4_t      d4;
  logic [3:0] k28Dec;
  logic [3:0] sub4Norm;

  assign d6 = dec6(sub6_i);
  assign d4 = dec4(sub4_i);

  // After 110000 the K28 fghj is the bitwise inverse of the 001111 form
  assign sub4Norm = (sub6_i == 6'b110000) ? ~sub4_i : sub4_i;
  assign k28Dec   = decK28(sub4Norm);

  assign k28_o     = (sub6_i == 6'b001111) || (sub6_i == 6'b110000);
  assign isA7_o    = (sub4_i == 4'b0111) || (sub4_i == 4'b1000);
  assign isP7_o    = (sub4_i == 4'b1110) || (sub4_i == 4'b0001);
  assign kx7_o     = d6.valid && !k28_o && isA7_o &&
                     (d6.edcba inside {5'd23, 5'd27, 5'd29, 5'd30});
  assign a7Minus_o = d6.valid && !k28_o && (d6.edcba inside {5'd17, 5'd18, 5'd20});
  assign a7Plus_o  = d6.valid && !k28_o && (d6.edcba inside {5'd11, 5'd13, 5'd14});

  assign edcba_o  = d6.edcba;
  assign valid6_o = d6.valid;
  assign cls6_o   = d6.cls;
  assign cls4_o   = d4.cls;
  assign valid4_o = k28_o ? k28Dec[3] : d4.valid;
  assign hgf_o    = k28_o ? k28Dec[2:0] : d4.hgf;
  assign comma_o  = k28_o && k28Dec[3] && (k28Dec[2:0] inside {3'd1, 3'd5, 3'd7});

endmodule

// File: rtl/decoder_8b10b.sv
// 8b/10b receive decoder: running-disparity tracking, error flags, one-cycle output register.
module decoder_8b10b
  import decoder_8b10b_pkg::*;
#(
  parameter logic RD_INIT = RD_MINUS
) (
  input  logic               clk,
  input  logic               rst,
  decoder_8b10b_if.slave     bus
);

  logic [4:0] edcba;
  logic [2:0] hgf;
  logic       valid6, valid4, k28, kx7, comma, a7Minus, a7Plus, isA7, isP7;
  cls_e       cls6, cls4;

  dec_6b4b_lut u_lut (
    .sub6_i    (bus.i_sym[9:4]),
    .sub4_i    (bus.i_sym[3:0]),
    .edcba_o   (edcba),
    .hgf_o     (hgf),
    .valid6_o  (valid6),
    .valid4_o  (valid4),
    .cls6_o    (cls6),
    .cls4_o    (cls4),
    .k28_o     (k28),
    .kx7_o     (kx7),
    .comma_o   (comma),
    .a7Minus_o (a7Minus),
    .a7Plus_o  (a7Plus),
    .isA7_o    (isA7),
    .isP7_o    (isP7)
  );

  logic       rdLine_q, rdOut_q, valid_q, k_q, comma_q, codeErr_q, dispErr_q;
  logic [7:0] data_q;
  logic       rdCur, rdMid, rdNext, a7Req;
  logic       codeErr_d, dispErr_d, k_d, comma_d;
  logic [7:0] data_d;

  // RD keeps following the received classes even on errors so we resync to the line
  always_comb begin
    rdCur     = bus.i_rd_clr ? RD_INIT : rdLine_q;
    rdMid     = rdApply(cls6, rdCur);
    rdNext    = rdApply(cls4, rdMid);
    a7Req     = (a7Minus && rdCur == RD_MINUS) || (a7Plus && rdCur == RD_PLUS);
    dispErr_d = (cls6 == CLS_P && rdCur == RD_PLUS) || (cls6 == CLS_N && rdCur == RD_MINUS) ||
                (cls4 == CLS_P && rdMid == RD_PLUS) || (cls4 == CLS_N && rdMid == RD_MINUS);
    codeErr_d = !valid6 || !valid4 ||
                (isA7 && !k28 && !kx7 && !a7Req) || (isP7 && a7Req);
    data_d    = codeErr_d ? 8'h00 : {hgf, edcba};
    k_d       = !codeErr_d && (k28 || kx7);
    comma_d   = !codeErr_d && comma;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      k_q       <= 1'b0;
      comma_q   <= 1'b0;
      codeErr_q <= 1'b0;
      dispErr_q <= 1'b0;
      rdOut_q   <= RD_INIT;
      rdLine_q  <= RD_INIT;
    end else begin
      valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        data_q    <= data_d;
        k_q       <= k_d;
        comma_q   <= comma_d;
        codeErr_q <= codeErr_d;
        dispErr_q <= dispErr_d;
        rdOut_q   <= rdNext;
        rdLine_q  <= rdNext;
      end else if (bus.i_rd_clr) begin
        rdLine_q <= RD_INIT;
      end
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_k        = k_q;
  assign bus.o_comma    = comma_q;
  assign bus.o_code_err = codeErr_q;
  assign bus.o_disp_err = dispErr_q;
  assign bus.o_rd       = rdOut_q;

endmodule

// File: tb/tb_decoder_8b10b.sv
// Scoreboard bench for decoder_8b10b: directed symbols with hand-computed decodes.
module tb_decoder_8b10b;
  import decoder_8b10b_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       comma;
    logic       codeErr;
    logic       dispErr;
    logic       rd;
  } exp_t;

  localparam exp_t RESET_EXP = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  logic clk;
  logic rst;
  decoder_8b10b_if dutIf ();

  decoder_8b10b #(.RD_INIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dutIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checkCount;
  int   passCount;
  logic monOn;
  logic rstQ;
  logic expValidQ;
  exp_t sb[$];
  exp_t lastExp;
  exp_t popExp;

  function automatic exp_t mk(input logic [7:0] d, input logic k, input logic c,
                              input logic ce, input logic de, input logic rd);
    return '{d, k, c, ce, de, rd};
  endfunction

  task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkField({tag, ".data"},    dutIf.o_data,              e.data);
    checkField({tag, ".k"},       {7'd0, dutIf.o_k},         {7'd0, e.k});
    checkField({tag, ".comma"},   {7'd0, dutIf.o_comma},     {7'd0, e.comma});
    checkField({tag, ".codeErr"}, {7'd0, dutIf.o_code_err},  {7'd0, e.codeErr});
    checkField({tag, ".dispErr"}, {7'd0, dutIf.o_disp_err},  {7'd0, e.dispErr});
    checkField({tag, ".rd"},      {7'd0, dutIf.o_rd},        {7'd0, e.rd});
  endtask

  task automatic applyStimulus(input logic v, input logic [9:0] s, input logic clr,
                               input logic r, input exp_t e);
    dutIf.i_valid  = v;
    dutIf.i_sym    = s;
    dutIf.i_rd_clr = clr;
    rst            = r;
    if (v && !r) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Reference o_valid pipeline and reset marker
  always @(posedge clk) begin
    rstQ      <= rst;
    expValidQ <= rst ? 1'b0 : dutIf.i_valid;
  end

  // Monitor: pop on o_valid, otherwise outputs must hold (or show reset values)
  always @(negedge clk) begin
    if (monOn) begin
      checkField("valid", {7'd0, dutIf.o_valid}, {7'd0, expValidQ});
      if (dutIf.o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_valid: got o_valid=1, expected empty scoreboard to stay idle");
        end else begin
          popExp  = sb.pop_front();
          lastExp = popExp;
          checkOutput("dec", popExp);
        end
      end else begin
        if (rstQ) lastExp = RESET_EXP;
        checkOutput("hold", lastExp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checkCount     = 0;
    passCount      = 0;
    monOn          = 1'b0;
    lastExp        = RESET_EXP;
    dutIf.i_valid  = 1'b0;
    dutIf.i_sym    = 10'd0;
    dutIf.i_rd_clr = 1'b0;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    monOn = 1'b1;
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b1, RESET_EXP);

    // Commas and data, RD tracking
    applyStimulus(1'b1, K_SYM_RDM[5],  1'b0, 1'b0, mk(8'hBC, 1, 1, 0, 0, 1));
    applyStimulus(1'b1, K_SYM_RDP[5],  1'b0, 1'b0, mk(8'hBC, 1, 1, 0, 0, 0));
    applyStimulus(1'b1, 10'b1010101010, 1'b0, 1'b0, mk(8'hB5, 0, 0, 0, 0, 0));
    applyStimulus(1'b1, 10'b0011111010, 1'b0, 1'b0, mk(8'hBC, 1, 1, 0, 0, 1));
    applyStimulus(1'b1, 10'b0011111010, 1'b0, 1'b0, mk(8'hBC, 1, 1, 0, 1, 1));
    // Illegal symbols, with an idle cycle between
    applyStimulus(1'b1, 10'b0000000000, 1'b0, 1'b0, mk(8'h00, 0, 0, 1, 1, 0));
    applyStimulus(1'b0, 10'b0011111010, 1'b0, 1'b0, RESET_EXP);
    applyStimulus(1'b1, 10'b1111111111, 1'b0, 1'b0, mk(8'h00, 0, 0, 1, 1, 1));
    // A7/P7 rules, decoded against forced RD-
    applyStimulus(1'b1, 10'b1000110111, 1'b1, 1'b0, mk(8'hF1, 0, 0, 0, 0, 1));
    applyStimulus(1'b1, 10'b1000111110, 1'b1, 1'b0, mk(8'h00, 0, 0, 1, 0, 1));
    // Mid-stream reset with RD=+
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b1, RESET_EXP);
    applyStimulus(1'b1, 10'b1100000101, 1'b0, 1'b0, mk(8'hBC, 1, 1, 0, 1, 0));
    applyStimulus(1'b1, 10'b0011111010, 1'b0, 1'b0, mk(8'hBC, 1, 1, 0, 0, 1));
    // RD clear alone, then with a symbol
    applyStimulus(1'b0, 10'd0, 1'b1, 1'b0, RESET_EXP);
    applyStimulus(1'b1, 10'b1100000101, 1'b0, 1'b0, mk(8'hBC, 1, 1, 0, 1, 0));
    applyStimulus(1'b1, 10'b0011111010, 1'b0, 1'b0, mk(8'hBC, 1, 1, 0, 0, 1));
    applyStimulus(1'b1, 10'b1100000101, 1'b1, 1'b0, mk(8'hBC, 1, 1, 0, 1, 0));
    // Other K codes, bad K28 tail, D0.0, A7 legality for x=11
    applyStimulus(1'b1, 10'b0011111000, 1'b0, 1'b0, mk(8'hFC, 1, 1, 0, 0, 0));
    applyStimulus(1'b1, 10'b1110101000, 1'b0, 1'b0, mk(8'hF7, 1, 0, 0, 0, 0));
    applyStimulus(1'b1, 10'b0011110001, 1'b0, 1'b0, mk(8'h00, 0, 0, 1, 0, 0));
    applyStimulus(1'b1, 10'b1001110100, 1'b0, 1'b0, mk(8'h00, 0, 0, 0, 0, 0));
    applyStimulus(1'b1, 10'b1101000111, 1'b0, 1'b0, mk(8'h00, 0, 0, 1, 0, 1));
    applyStimulus(1'b1, 10'b1101001000, 1'b0, 1'b0, mk(8'hEB, 0, 0, 0, 0, 0));

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, RESET_EXP);

    checkCount++;
    if (sb.size() == 0) passCount++;
    else $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());

    monOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
